// File: rtl/nw_pkg.sv
// Shared Needleman-Wunsch definitions: direction symbols, default scoring and fill FSM states.
package nw_pkg;

  localparam logic [2:0] DIR_NONE = 3'b000;
  localparam logic [2:0] DIAG     = 3'b001;
  localparam logic [2:0] UP       = 3'b010;
  localparam logic [2:0] LEFT     = 3'b100;

  localparam int MATCH_DEF    = 1;
  localparam int MISMATCH_DEF = -1;
  localparam int GAP_DEF      = -2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CALC,
    ST_WR,
    ST_ADV,
    ST_DONE
  } fill_state_t;

endpackage

// File: rtl/direction_matrix_writer_if.sv
// Bus between the fill-phase writer and its score/direction RAM environment.
interface direction_matrix_writer_if #(
  parameter int W       = 12,
  parameter int BitAddr = 8
);
  logic                 en_fill;
  logic                 match;
  logic signed [W-1:0]  h_diag;
  logic signed [W-1:0]  h_up;
  logic signed [W-1:0]  h_left;
  logic [BitAddr:0]     i_f;
  logic [BitAddr:0]     j_f;
  logic                 rd_en;
  logic [BitAddr:0]     i_f_ram;
  logic [BitAddr:0]     j_f_ram;
  logic                 we;
  logic [2:0]           dir_sym;
  logic signed [W-1:0]  score_wr;
  logic                 end_f;

  modport master (
    output en_fill, match, h_diag, h_up, h_left,
    input  i_f, j_f, rd_en, i_f_ram, j_f_ram, we, dir_sym, score_wr, end_f
  );

  modport slave (
    input  en_fill, match, h_diag, h_up, h_left,
    output i_f, j_f, rd_en, i_f_ram, j_f_ram, we, dir_sym, score_wr, end_f
  );
endinterface

// File: rtl/direction_matrix_writer_max3_dir.sv
// Three-way signed max with DIAG > UP > LEFT tie priority; returns winner score and symbol.
module max3_dir
  import nw_pkg::*;
#(
  parameter int W = 12
) (
  input  logic signed [W-1:0] diag,
  input  logic signed [W-1:0] up,
  input  logic signed [W-1:0] left,
  output logic signed [W-1:0] score,
  output logic [2:0]          dir_sym
);

  always_comb begin
    score   = diag;
    dir_sym = DIAG;
    if (!(diag >= up && diag >= left)) begin
      if (up >= left) begin
        score   = up;
        dir_sym = UP;
      end else begin
        score   = left;
        dir_sym = LEFT;
      end
    end
  end

endmodule

// File: rtl/direction_matrix_writer.sv
// Needleman-Wunsch fill stage: walks the N x N interior row-major, four cycles per cell,
// writing each cell score and winning direction symbol.
module direction_matrix_writer
  import nw_pkg::*;
#(
  parameter int N        = 128,
  parameter int BitAddr  = $clog2(N + 1),
  parameter int W        = 12,
  parameter int MATCH    = MATCH_DEF,
  parameter int MISMATCH = MISMATCH_DEF,
  parameter int GAP      = GAP_DEF
) (
  input logic                clk,
  input logic                rst,
  direction_matrix_writer_if.slave bus
);

  localparam int unsigned IW = BitAddr + 1;
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N);

  fill_state_t          state;
  logic [IW-1:0]        i_f;
  logic [IW-1:0]        j_f;
  logic                 rd_en;
  logic                 we;
  logic                 end_f;
  logic [2:0]           dir_sym;
  logic signed [W-1:0]  score_wr;

  logic [W:0]           diag_sum;
  logic [W:0]           up_sum;
  logic [W:0]           left_sum;
  logic signed [W-1:0]  diag_c;
  logic signed [W-1:0]  up_c;
  logic signed [W-1:0]  left_c;
  logic signed [W-1:0]  best_score;
  logic [2:0]           best_dir;

  // Candidates are formed one bit wider and wrapped back to W bits; no saturation.
  always_comb begin
    diag_sum = {bus.h_diag[W-1], bus.h_diag} + (W+1)'(bus.match ? MATCH : MISMATCH);
    up_sum   = {bus.h_up[W-1],   bus.h_up}   + (W+1)'(GAP);
    left_sum = {bus.h_left[W-1], bus.h_left} + (W+1)'(GAP);
    diag_c   = diag_sum[W-1:0];
    up_c     = up_sum[W-1:0];
    left_c   = left_sum[W-1:0];
  end

  max3_dir #(.W(W)) u_max3_dir (
    .diag    (diag_c),
    .up      (up_c),
    .left    (left_c),
    .score   (best_score),
    .dir_sym (best_dir)
  );

  // FSM, index counters and registered strobes; strobes are set on entry to their state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      i_f      <= IDX_ONE;
      j_f      <= IDX_ONE;
      rd_en    <= 1'b0;
      we       <= 1'b0;
      end_f    <= 1'b0;
      dir_sym  <= DIR_NONE;
      score_wr <= '0;
    end else begin
      rd_en <= 1'b0;
      we    <= 1'b0;
      case (state)
        ST_IDLE: begin
          i_f <= IDX_ONE;
          j_f <= IDX_ONE;
          if (bus.en_fill) begin
            state <= ST_RD;
            rd_en <= 1'b1;
          end
        end
        ST_RD: state <= ST_CALC;
        ST_CALC: begin
          dir_sym  <= best_dir;
          score_wr <= best_score;
          we       <= 1'b1;
          state    <= ST_WR;
        end
        ST_WR: state <= ST_ADV;
        ST_ADV: begin
          if (j_f != IDX_LAST) begin
            j_f   <= j_f + IDX_ONE;
            state <= ST_RD;
            rd_en <= 1'b1;
          end else if (i_f != IDX_LAST) begin
            j_f   <= IDX_ONE;
            i_f   <= i_f + IDX_ONE;
            state <= ST_RD;
            rd_en <= 1'b1;
          end else begin
            state <= ST_DONE;
            end_f <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!bus.en_fill) begin
            state <= ST_IDLE;
            end_f <= 1'b0;
            i_f   <= IDX_ONE;
            j_f   <= IDX_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.i_f      = i_f;
  assign bus.j_f      = j_f;
  assign bus.i_f_ram  = i_f - IDX_ONE;
  assign bus.j_f_ram  = j_f - IDX_ONE;
  assign bus.rd_en    = rd_en;
  assign bus.we       = we;
  assign bus.end_f    = end_f;
  assign bus.dir_sym  = dir_sym;
  assign bus.score_wr = score_wr;

endmodule

// File: tb/tb_direction_matrix_writer.sv
// Self-checking bench for direction_matrix_writer at N=4, W=8: table vectors, random cells,
// and full fills against a score-RAM model and a reference NW matrix.
module tb_direction_matrix_writer;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int BA = $clog2(N + 1);
  localparam logic [2:0] S_DIAG = 3'b001;
  localparam logic [2:0] S_UP   = 3'b010;
  localparam logic [2:0] S_LEFT = 3'b100;

  typedef struct {
    int         hd;
    int         hu;
    int         hl;
    bit         m;
    logic [2:0] exp_dir;
    int         exp_score;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  direction_matrix_writer_if #(.W(W), .BitAddr(BA)) bus ();

  direction_matrix_writer #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bit   ram_mode = 1'b0;
  logic signed [W-1:0] tb_hd = '0, tb_hu = '0, tb_hl = '0;
  logic                tb_m  = 1'b0;
  logic signed [W-1:0] ram_hd = '0, ram_hu = '0, ram_hl = '0;
  logic                ram_m  = 1'b0;

  assign bus.h_diag = ram_mode ? ram_hd : tb_hd;
  assign bus.h_up   = ram_mode ? ram_hu : tb_hu;
  assign bus.h_left = ram_mode ? ram_hl : tb_hl;
  assign bus.match  = ram_mode ? ram_m  : tb_m;

  int n_vec = 0;
  int n_err = 0;
  int hm [0:N][0:N];
  int seq_a [N];
  int seq_b [N];
  int cell_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int wrap(input int x);
    int r;
    r = ((x % 256) + 256) % 256;
    if (r > 127) r -= 256;
    return r;
  endfunction

  // Reference cell rule: wrapped candidates, first of diag/up/left wins ties.
  task automatic ref_cell(input int hd, input int hu, input int hl, input bit m,
                          output logic [2:0] dir, output int score);
    int d, u, l;
    d = wrap(hd + (m ? 1 : -1));
    u = wrap(hu - 2);
    l = wrap(hl - 2);
    if (d >= u && d >= l) begin dir = S_DIAG; score = d; end
    else if (u >= l)      begin dir = S_UP;   score = u; end
    else                  begin dir = S_LEFT; score = l; end
  endtask

  // Score RAM model with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_mode) begin
      if (bus.rd_en) begin
        ram_hd <= W'(hm[bus.i_f-1][bus.j_f-1]);
        ram_hu <= W'(hm[bus.i_f-1][bus.j_f]);
        ram_hl <= W'(hm[bus.i_f][bus.j_f-1]);
        ram_m  <= (seq_a[bus.i_f-1] == seq_b[bus.j_f-1]);
      end
      if (bus.we)
        hm[bus.i_f_ram+1][bus.j_f_ram+1] <= int'(bus.score_wr);
    end
  end

  task automatic check_write(input string tag, input logic [2:0] dir, input int score);
    chk({tag, "_dir"},   int'(bus.dir_sym), int'(dir));
    chk({tag, "_score"}, int'(bus.score_wr), score);
    chk({tag, "_i_ram"}, int'(bus.i_f_ram), cell_cnt / N);
    chk({tag, "_j_ram"}, int'(bus.j_f_ram), cell_cnt % N);
    chk({tag, "_rd_we"}, int'(bus.rd_en), 0);
  endtask

  // Hold one vector on the inputs until the next write, restarting the fill if it finished.
  task automatic do_cell(input vec_t v, input string tag);
    bit got;
    int cyc;
    tb_hd = W'(v.hd); tb_hu = W'(v.hu); tb_hl = W'(v.hl); tb_m = v.m;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.end_f) begin
        bus.en_fill = 1'b0;
        @(negedge clk);
        bus.en_fill = 1'b1;
        cell_cnt = 0;
      end
      if (bus.we) got = 1'b1;
    end
    chk({tag, "_got_we"}, int'(got), 1);
    if (got) begin
      check_write(tag, v.exp_dir, v.exp_score);
      cell_cnt++;
    end
  endtask

  // Full fill from IDLE with the RAM model; drop_at>0 lowers en_fill at that cycle.
  task automatic run_pass(input string tag, input int drop_at, input bit acgt);
    int e [0:N][0:N];
    logic [2:0] ed [1:N][1:N];
    int k, c;
    bit done_seen;
    for (int i = 0; i <= N; i++) begin
      hm[i][0] = -2 * i; hm[0][i] = -2 * i;
      e[i][0]  = -2 * i; e[0][i]  = -2 * i;
    end
    for (int i = 1; i <= N; i++)
      for (int j = 1; j <= N; j++)
        ref_cell(e[i-1][j-1], e[i-1][j], e[i][j-1], seq_a[i-1] == seq_b[j-1], ed[i][j], e[i][j]);
    ram_mode = 1'b1;
    @(negedge clk);
    bus.en_fill = 1'b1;
    k = 0;
    cell_cnt = 0;
    done_seen = 1'b0;
    for (c = 1; c <= 200 && !done_seen; c++) begin
      @(negedge clk);
      if (c == drop_at) bus.en_fill = 1'b0;
      if (bus.we) begin
        chk({tag, "_we_cycle"}, c, 3 + 4 * k);
        if (k < N * N) check_write(tag, ed[k/N+1][k%N+1], e[k/N+1][k%N+1]);
        k++;
        cell_cnt++;
      end
      if (bus.end_f) begin
        done_seen = 1'b1;
        chk({tag, "_end_cycle"}, c, 4 * N * N + 1);
      end
    end
    chk({tag, "_done_seen"}, int'(done_seen), 1);
    chk({tag, "_writes"}, k, N * N);
    if (acgt)
      for (int d = 1; d <= N; d++) chk({tag, "_diag_score"}, hm[d][d], d);
  endtask

  vec_t vecs[$];
  vec_t v;
  int   bad;

  initial begin
    bus.en_fill = 1'b0;
    cell_cnt = 0;

    vecs.push_back('{0,    1,    1,    1'b0, S_DIAG, -1});
    vecs.push_back('{-3,   1,    1,    1'b0, S_UP,   -1});
    vecs.push_back('{5,    0,    10,   1'b1, S_LEFT, 8});
    vecs.push_back('{-128, -128, -128, 1'b0, S_DIAG, 127});
    vecs.push_back('{-128, -128, -128, 1'b1, S_UP,   126});
    vecs.push_back('{-128, -128, -127, 1'b1, S_LEFT, 127});
    vecs.push_back('{127,  0,    0,    1'b1, S_UP,   -2});
    vecs.push_back('{3,    6,    2,    1'b1, S_DIAG, 4});
    vecs.push_back('{0,    -5,   3,    1'b0, S_LEFT, 1});
    vecs.push_back('{10,   13,   13,   1'b1, S_DIAG, 11});
    for (int r = 0; r < 20; r++) begin
      v.hd = int'($urandom_range(0, 255)) - 128;
      v.hu = int'($urandom_range(0, 255)) - 128;
      v.hl = int'($urandom_range(0, 255)) - 128;
      v.m  = 1'($urandom_range(0, 1));
      ref_cell(v.hd, v.hu, v.hl, v.m, v.exp_dir, v.exp_score);
      vecs.push_back(v);
    end

    repeat (3) @(negedge clk);
    chk("rst_i_f", int'(bus.i_f), 1);
    chk("rst_j_f", int'(bus.j_f), 1);
    chk("rst_i_ram", int'(bus.i_f_ram), 0);
    chk("rst_we_rd_end", int'({bus.we, bus.rd_en, bus.end_f}), 0);
    chk("rst_dir_score", int'(bus.dir_sym) + int'(bus.score_wr), 0);
    rst = 1'b0;

    // Table and random vectors across two fills, incl. index wrap and restart.
    @(negedge clk);
    bus.en_fill = 1'b1;
    for (int t = 0; t < vecs.size(); t++) do_cell(vecs[t], $sformatf("vec%0d", t));

    // Asynchronous reset in the middle of a write cycle.
    bad = 1;
    for (int c = 0; c < 40 && bad == 1; c++) begin
      @(negedge clk);
      if (bus.we) bad = 0;
    end
    chk("mid_find_we", bad, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_we", int'(bus.we), 0);
    chk("mid_rst_rd_end", int'({bus.rd_en, bus.end_f}), 0);
    chk("mid_rst_idx", int'({bus.i_f, bus.j_f}), int'({4'd1, 4'd1}));
    chk("mid_rst_ram", int'({bus.i_f_ram, bus.j_f_ram}), 0);
    chk("mid_rst_out", int'({bus.dir_sym, bus.score_wr}), 0);
    bus.en_fill = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.we || bus.rd_en || bus.end_f) bad++;
    end
    chk("idle_after_rst", bad, 0);

    // Full pass on ACGT vs ACGT with en_fill held high.
    seq_a = '{0, 1, 2, 3};
    seq_b = '{0, 1, 2, 3};
    run_pass("acgt", 0, 1'b1);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.end_f || bus.we || bus.rd_en) bad++;
    end
    chk("done_hold", bad, 0);
    bus.en_fill = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("done_exit_end", int'(bus.end_f), 0);
    chk("done_exit_idx", int'({bus.i_f, bus.j_f}), int'({4'd1, 4'd1}));

    // Random sequences, en_fill dropped during cell 5.
    for (int i = 0; i < N; i++) begin
      seq_a[i] = int'($urandom_range(0, 3));
      seq_b[i] = int'($urandom_range(0, 3));
    end
    run_pass("rnd", 22, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/direction_matrix_writer.md
# direction_matrix_writer

Fill-phase counterpart of the traceback reader. Walks the N×N interior of the Needleman–Wunsch matrix in row-major order, four cycles per cell. For each cell it requests neighbour scores, computes the cell score and the winning direction symbol, and writes both to the score and direction RAMs. The direction RAM it produces is the one the traceback stage later consumes, so it uses the same UP/LEFT/DIAG encoding and the same (i−1, j−1) RAM addressing.

## Interface
Parameters:
- N, 128, sequence length; the interior matrix is N×N.
- BitAddr, $clog2(N+1), index width minus 1. Indices are BitAddr+1 bits.
- W, 12, signed score width.
- MATCH, 1, added on the diagonal when the characters are equal.
- MISMATCH, -1, added on the diagonal when the characters differ.
- GAP, -2, added on the up and left moves.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en_fill  in  1  start request; level, sampled only in IDLE and DONE
- match  in  1  seqA[i−1]==seqB[j−1]; valid in CALC
- h_diag, h_up, h_left  in  W signed  H(i−1,j−1), H(i−1,j), H(i,j−1); valid in CALC
- i_f, j_f  out  BitAddr+1  current cell index, range 1..N
- rd_en  out  1  neighbour-score read request; high in RD only
- i_f_ram, j_f_ram  out  BitAddr+1  write address, equal to i_f−1 and j_f−1
- we  out  1  write strobe for both RAMs; high in WR only
- dir_sym  out  3  UP=3'b010, LEFT=3'b100, DIAG=3'b001
- score_wr  out  W signed  H(i,j)
- end_f  out  1  fill complete; high in DONE

## Operation
States: IDLE, RD, CALC, WR, ADV, DONE.
- **IDLE:** i_f=1, j_f=1. Goes to RD when en_fill=1.
- **RD:** rd_en=1. Always goes to CALC.
- **CALC:** the datapath registers the candidates. If several candidates are equal, the earliest in the list below wins:
  - diag = h_diag + (match ? MATCH : MISMATCH)
  - up = h_up + GAP
  - left = h_left + GAP
  
  dir_sym and score_wr latch the winner at the end of CALC. Always goes to WR.
- **WR:** we=1, with addresses, dir_sym and score_wr stable. Always goes to ADV.
- **ADV:**
  - j_f<N: j_f+1, next state RD.
  - j_f==N and i_f<N: j_f=1, i_f+1, next state RD.
  - i_f==N and j_f==N: indices hold, next state DONE.
- **DONE:** end_f=1 and indices hold. When en_fill=0, go to IDLE and reload i_f=j_f=1.
- en_fill is ignored between RD and ADV. A started fill always completes.
- Arithmetic:
  - Sums are computed at W+1 bits and truncated to W bits.
  - No saturation. W must cover ±(2·GAP·N); 12 bits is enough for N≤256 at the default GAP.
- i_f_ram and j_f_ram are combinational from i_f and j_f, and are never negative because i_f, j_f ≥ 1.

## Timing
- Reset values:
  - state IDLE
  - i_f=1, j_f=1, i_f_ram=0, j_f_ram=0
  - rd_en=0, we=0, end_f=0
  - dir_sym=3'b000, score_wr=0
- Cycle numbering: en_fill is sampled high in IDLE at cycle 0.
  - Cell k (k=0..N²−1): RD at cycle 1+4k, CALC at 2+4k, WR at 3+4k, ADV at 4+4k.
  - Neighbour scores must be valid throughout the CALC cycle, which is one cycle after rd_en (one-cycle RAM read latency).
  - DONE is entered at cycle 4N²+1, and end_f rises on that edge.
- The WR of cell k precedes the RD of cell k+1. A score written in cycle 3+4k is therefore readable as h_left for cell k+1.
- Asynchronous rst at any point:
  - we, rd_en and end_f drop immediately.
  - The partial cell is not written.
  - After release, the block restarts only on en_fill.
- rd_en and we are never high in the same cycle. Each cell produces exactly one we pulse.

## Structure
- Shared package nw_pkg:
  - UP, LEFT, DIAG symbol constants (shared with the traceback reader)
  - MATCH, MISMATCH, GAP defaults
  - the fill state enum
- Sub-module max3_dir: combinational three-way signed max with DIAG>UP>LEFT priority. It outputs the winning score and dir_sym, and is reusable by a future banded variant.
- The top holds the FSM, the index counters and the output registers.

## Test plan
All scenarios use N=4 and W=8.
- **Reset values:** assert rst mid-run → all outputs hold their reset values immediately; release with en_fill=0 → stays in IDLE, we never pulses.
- **Full pass on real data:** seqA=seqB="ACGT", with a score RAM model seeded with borders H(i,0)=−2i and H(0,j)=−2j.
  - 16 we pulses, spaced every 4 cycles.
  - Diagonal cells get DIAG with scores 1,2,3,4.
  - end_f rises at cycle 65.
- **Ties:**
  - h_diag=0, match=0, h_up=1, h_left=1 → up=−1, diag=−1 → DIAG, score −1.
  - h_diag=−3, match=0, h_up=1, h_left=1 → up=left=−1 → UP.
- **Index wrap:** at (1,4), ADV → (2,1), with i_f_ram=1 and j_f_ram=0 at the next WR.
- **Enable handling:**
  - Drop en_fill during cell 5 → the run still finishes with 16 writes.
  - Hold en_fill high in DONE → stays in DONE.
  - Drop then raise en_fill → a new run starts from (1,1).
- **Truncation at the width limit:** h_up=−128, h_diag=−128, h_left=−128 with W=8 → the wrapped result matches the W+1-bit-then-truncate reference model.
